// File: rtl/rv_pkg.sv
// Shared RV32I constants and the sequencer state type used by the program-driving front end.
package rv_pkg;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CHECK,
      S_WAIT,
      S_SETTLE,
      S_HALT,
      S_FAULT
   } seq_state_t;

endpackage

// File: rtl/instr_ram.sv
// Single-port synchronous instruction RAM, write-first, contents not reset.
module instr_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Issues program-RAM words to the core one at a time over run/done, indexed by the core PC.
module instr_sequencer
   import rv_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [31:0]              load_data,
   input  logic                     start,
   input  logic                     stop,
   input  logic [31:0]              pc,
   input  logic                     done,
   output logic [31:0]              command,
   output logic                     run,
   output logic                     busy,
   output logic                     halted,
   output logic                     fault,
   output logic [CNT_W-1:0]         issued_count
);

   localparam int AW = $clog2(DEPTH);

   seq_state_t    state, state_nx;
   logic          stop_q;
   logic          idle_like;
   logic          load_ok;
   logic          accept_start;
   logic          stop_seen;
   logic          pc_bad;
   logic          do_issue;
   logic          do_count;
   logic          do_halt;
   logic          do_fault;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_rdata;

   assign idle_like    = (state == S_IDLE) || (state == S_HALT) || (state == S_FAULT);
   assign busy         = ~idle_like;
   assign load_ok      = load_en & idle_like;
   assign accept_start = start & idle_like;
   assign stop_seen    = stop | stop_q;
   // DEPTH is a power of two, so "word index >= DEPTH" is any set bit above the index field.
   assign pc_bad       = (pc[1:0] != 2'b00) || (|pc[31:AW+2]);
   assign ram_addr     = load_ok ? load_addr : pc[AW+1:2];

   instr_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (load_ok),
      .addr  (ram_addr),
      .wdata (load_data),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nx = state;
      do_issue = 1'b0;
      do_count = 1'b0;
      do_halt  = 1'b0;
      do_fault = 1'b0;
      case (state)
         S_IDLE, S_HALT, S_FAULT: begin
            if (start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (stop_seen) begin
               state_nx = S_IDLE;
            end else if (pc_bad) begin
               state_nx = S_FAULT;
               do_fault = 1'b1;
            end else begin
               state_nx = S_CHECK;
            end
         end
         S_CHECK: begin
            if (stop_seen) begin
               state_nx = S_IDLE;
            end else if (ram_rdata == ECALL_WORD) begin
               state_nx = S_HALT;
               do_halt  = 1'b1;
            end else begin
               state_nx = S_WAIT;
               do_issue = 1'b1;
            end
         end
         S_WAIT: begin
            if (done) begin
               state_nx = S_SETTLE;
               do_count = 1'b1;
            end
         end
         S_SETTLE: begin
            state_nx = stop_seen ? S_IDLE : S_FETCH;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         stop_q       <= 1'b0;
         command      <= '0;
         run          <= 1'b0;
         halted       <= 1'b0;
         fault        <= 1'b0;
         issued_count <= '0;
      end else begin
         state <= state_nx;

         if (state_nx == S_IDLE) stop_q <= 1'b0;
         else if (stop && busy)  stop_q <= 1'b1;

         if (accept_start) begin
            issued_count <= '0;
            halted       <= 1'b0;
            fault        <= 1'b0;
         end else begin
            if (do_count) issued_count <= issued_count + 1'b1;
            if (do_halt)  halted       <= 1'b1;
            if (do_fault) fault        <= 1'b1;
         end

         if (do_issue) begin
            command <= ram_rdata;
            run     <= 1'b1;
         end else if (do_count) begin
            run     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized bench for instr_sequencer with a list-walking program model.
module tb_instr_sequencer;

   localparam int DEPTH = 64;
   localparam int CNT_W = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [31:0] ECALL   = 32'h0000_0073;
   localparam logic [31:0] ADDI16  = 32'h0100_0093;
   localparam logic [31:0] ADDI1   = 32'h0010_0093;
   localparam logic [31:0] ADDI2   = 32'h0020_0113;
   localparam logic [31:0] JAL32   = 32'h0200_006F;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             load_en = 1'b0;
   logic [AW-1:0]    load_addr = '0;
   logic [31:0]      load_data = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [31:0]      pc = '0;
   logic             done = 1'b0;
   logic [31:0]      command;
   logic             run;
   logic             busy;
   logic             halted;
   logic             fault;
   logic [CNT_W-1:0] issued_count;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model_ram [DEPTH];

   instr_sequencer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .start        (start),
      .stop         (stop),
      .pc           (pc),
      .done         (done),
      .command      (command),
      .run          (run),
      .busy         (busy),
      .halted       (halted),
      .fault        (fault),
      .issued_count (issued_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int addr, input logic [31:0] data);
      load_en   = 1'b1;
      load_addr = addr[AW-1:0];
      load_data = data;
      step();
      load_en   = 1'b0;
      model_ram[addr] = data;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_run(input string tag);
      int t = 0;
      while (run !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      check({tag, "_run_seen"}, {31'd0, run}, 32'd1);
   endtask

   // Core model: completes lat cycles after the command appears, then moves its PC.
   task automatic serve(input int lat, input logic [31:0] npc, input logic [31:0] exp_cmd,
                        input string tag);
      wait_run(tag);
      check({tag, "_cmd"}, command, exp_cmd);
      repeat (lat - 1) step();
      done = 1'b1;
      step();
      done = 1'b0;
      pc   = npc;
   endtask

   task automatic wait_quiet(input string tag);
      int t = 0;
      while (busy !== 1'b0 && t < 400) begin
         step();
         t++;
      end
      check({tag, "_quiet"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] exp_q [$];
      logic [31:0] npc_q [$];
      int          runs_seen;

      #1;
      check("rst_command", command, 32'd0);
      check("rst_run", {31'd0, run}, 32'd0);
      check("rst_count", {16'd0, issued_count}, 32'd0);
      check("rst_flags", {29'd0, busy, halted, fault}, 32'd0);
      step();
      reset = 1'b0;
      step();

      // Basic ADDI then ECALL, with exact issue timing.
      load_word(0, ADDI16);
      load_word(1, ECALL);
      pc = 32'd0;
      pulse_start();
      check("t1_e0_run", {31'd0, run}, 32'd0);
      step();
      check("t1_e1_run", {31'd0, run}, 32'd0);
      step();
      check("t1_e2_run", {31'd0, run}, 32'd1);
      check("t1_e2_cmd", command, ADDI16);
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      pc   = 32'd4;
      check("t1_done_run", {31'd0, run}, 32'd0);
      check("t1_done_cnt", {16'd0, issued_count}, 32'd1);
      wait_quiet("t1");
      check("t1_halted", {31'd0, halted}, 32'd1);
      check("t1_fault", {31'd0, fault}, 32'd0);
      check("t1_count", {16'd0, issued_count}, 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      check("t1_stray_done", {16'd0, issued_count}, 32'd1);

      // JAL: core jumps to word 8 which holds ECALL.
      load_word(0, JAL32);
      load_word(1, ADDI1);
      load_word(8, ECALL);
      pc = 32'd0;
      pulse_start();
      serve(2, 32'd32, JAL32, "jal");
      wait_quiet("jal");
      check("jal_halted", {31'd0, halted}, 32'd1);
      check("jal_count", {16'd0, issued_count}, 32'd1);

      // Misaligned and out-of-range PCs fault one cycle after start.
      pc = 32'd6;
      pulse_start();
      check("f6_flags_clr", {30'd0, halted, run}, 32'd0);
      step();
      check("f6_fault", {31'd0, fault}, 32'd1);
      check("f6_run", {31'd0, run}, 32'd0);
      check("f6_busy", {31'd0, busy}, 32'd0);
      pc = 32'(4 * DEPTH);
      pulse_start();
      check("foor_fault_clr", {31'd0, fault}, 32'd0);
      step();
      check("foor_fault", {31'd0, fault}, 32'd1);
      check("foor_run", {31'd0, run}, 32'd0);
      check("foor_halted", {31'd0, halted}, 32'd0);

      // Stop mid-WAIT, completion arrives 5 cycles later.
      load_word(0, ADDI16);
      load_word(1, ADDI2);
      load_word(2, ECALL);
      pc = 32'd0;
      pulse_start();
      wait_run("stp");
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stp_hold0", {31'd0, run}, 32'd1);
      repeat (3) begin
         step();
         check("stp_hold", {31'd0, run}, 32'd1);
      end
      check("stp_cmd_hold", command, ADDI16);
      done = 1'b1;
      step();
      done = 1'b0;
      pc   = 32'd4;
      check("stp_cnt", {16'd0, issued_count}, 32'd1);
      check("stp_run_drop", {31'd0, run}, 32'd0);
      step();
      check("stp_idle", {31'd0, busy}, 32'd0);
      runs_seen = 0;
      repeat (10) begin
         step();
         if (run === 1'b1 || busy === 1'b1) runs_seen++;
      end
      check("stp_no_fetch", runs_seen, 32'd0);
      check("stp_halted", {31'd0, halted}, 32'd0);

      // start and load_en during WAIT are ignored.
      pc = 32'd0;
      pulse_start();
      wait_run("ign");
      step();
      start     = 1'b1;
      load_en   = 1'b1;
      load_addr = '0;
      load_data = 32'hDEAD_BEEF;
      step();
      start   = 1'b0;
      load_en = 1'b0;
      check("ign_run", {31'd0, run}, 32'd1);
      check("ign_busy", {31'd0, busy}, 32'd1);
      stop = 1'b1;
      done = 1'b1;
      step();
      stop = 1'b0;
      done = 1'b0;
      pc   = 32'd4;
      check("ign_cnt", {16'd0, issued_count}, 32'd1);
      wait_quiet("ign");
      check("ign_halted", {31'd0, halted}, 32'd0);
      pc = 32'd0;
      pulse_start();
      wait_run("ign_rb");
      check("ign_readback", command, model_ram[0]);
      stop = 1'b1;
      done = 1'b1;
      step();
      stop = 1'b0;
      done = 1'b0;
      wait_quiet("ign_rb");

      // Asynchronous reset mid-handshake.
      pc = 32'd0;
      pulse_start();
      serve(1, 32'd4, ADDI16, "rst1");
      wait_run("rst2");
      check("rst_pre_cnt", {16'd0, issued_count}, 32'd1);
      check("rst_pre_cmd", command, ADDI2);
      #2;
      reset = 1'b1;
      #1;
      check("arst_run", {31'd0, run}, 32'd0);
      check("arst_cmd", command, 32'd0);
      check("arst_cnt", {16'd0, issued_count}, 32'd0);
      reset = 1'b0;
      step();
      check("arst_busy", {31'd0, busy}, 32'd0);

      // Randomized straight-line programs ending in ECALL or a wild jump.
      for (int it = 0; it < 12; it++) begin
         int          n;
         int          b;
         bit          ends_fault;
         logic [31:0] w;
         logic [31:0] bad;
         n = int'($urandom_range(1, 6));
         b = int'($urandom_range(0, DEPTH - n - 1));
         ends_fault = 1'($urandom_range(0, 1));
         exp_q.delete();
         npc_q.delete();
         for (int k = 0; k < n; k++) begin
            w = $urandom;
            if (w == ECALL) w = w ^ 32'h1;
            load_word(b + k, w);
            exp_q.push_back(w);
            npc_q.push_back(32'(4 * (b + k + 1)));
         end
         if (ends_fault) begin
            if ($urandom_range(0, 1) == 0)
               bad = 32'(4 * DEPTH + 4 * int'($urandom_range(0, 15)));
            else
               bad = 32'(4 * int'($urandom_range(0, DEPTH - 1)) + int'($urandom_range(1, 3)));
            npc_q[n-1] = bad;
         end else begin
            load_word(b + n, ECALL);
         end
         pc = 32'(4 * b);
         pulse_start();
         for (int k = 0; k < n; k++)
            serve(int'($urandom_range(1, 4)), npc_q[k], exp_q[k], "rnd");
         wait_quiet("rnd");
         check("rnd_count", {16'd0, issued_count}, 32'(n));
         check("rnd_halted", {31'd0, halted}, {31'd0, ~ends_fault});
         check("rnd_fault", {31'd0, fault}, {31'd0, ends_fault});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
